reaction_session_ctrl: RTL and testbench

Session scheduler for the reaction-timer game FSM. It owns the millisecond timer that feeds the FSM's iTimer16 and the pseudo-random requested-button generator that feeds iButtonRequested. It holds the FSM in reset between sessions, runs exactly NUM_TRIALS trials, and classifies each trial result. It also accumulates session statistics for the display layer.

---
 rtl/reaction_session_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl
// Session scheduler for the reaction-timer game FSM. Provides the millisecond
// timer and the pseudo-random requested button, holds the game FSM in reset
// between sessions, runs NUM_TRIALS trials and accumulates session statistics.
//
// Ports:
//   iClk                   system clock
//   iRst                   synchronous active-high reset
//   iStart                 start pulse, honoured in IDLE or DONE only
//   iResetTimer            clears the ms timer (wins over a coincident tick)
//   iNewButtonReq          latch a new requested button from the LFSR
//   iShowTimerErrorDisplay rising edge marks a trial result
//   iButtonError[1:0]      00 correct, 01 wrong, 10 timeout
//   oFsmRst                registered reset for the game FSM
//   oTimer16[15:0]         ms since last iResetTimer, saturating
//   oButtonRequested[2:0]  one-hot requested button
//   oTrialCount[4:0]       trials completed this session
//   oBestTime[15:0]        fastest correct response, FFFF if none
//   oTotalTime[19:0]       sum of correct response times
//   oWrongCount[4:0]       wrong-button results
//   oTimeoutCount[4:0]     timeout results
//   oSessionDone           high in DONE
//   oBusy                  high while a session is in progress
module reaction_session_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned NUM_TRIALS  = 8,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iResetTimer,
  input  logic        iNewButtonReq,
  input  logic        iShowTimerErrorDisplay,
  input  logic [1:0]  iButtonError,
  output logic        oFsmRst,
  output logic [15:0] oTimer16,
  output logic [2:0]  oButtonRequested,
  output logic [4:0]  oTrialCount,
  output logic [15:0] oBestTime,
  output logic [19:0] oTotalTime,
  output logic [4:0]  oWrongCount,
  output logic [4:0]  oTimeoutCount,
  output logic        oSessionDone,
  output logic        oBusy
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [4:0] TRIALS    = 5'(NUM_TRIALS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_RECORD,
    S_WAIT_RELEASE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [PW-1:0] r_presc;
  logic [15:0] r_timer;
  logic [7:0]  r_lfsr;
  logic        w_lfsr_fb;
  logic [2:0]  r_button;
  logic        r_fsm_rst;
  logic        r_show_prev;
  logic [15:0] r_cap_time;
  logic [1:0]  r_cap_err;
  logic [4:0]  r_trial_count;
  logic [15:0] r_best;
  logic [19:0] r_total;
  logic [4:0]  r_wrong;
  logic [4:0]  r_timeout;

  logic        w_show_rise;
  logic        w_clear_stats;
  logic        w_capture;
  logic        w_record;
  logic [4:0]  w_count_inc;

  // Millisecond timer; a clear request overrides a coincident tick.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (iResetTimer) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      if (r_timer != '1) begin
        r_timer <= r_timer + 16'd1;
      end
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free running.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_lfsr   <= SEED;
      r_button <= 3'b001;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      if (iNewButtonReq) begin
        unique case (r_lfsr[1:0])
          2'b01:   r_button <= 3'b010;
          2'b10:   r_button <= 3'b100;
          default: r_button <= 3'b001;
        endcase
      end
    end
  end

  // Session FSM
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_fsm_rst   <= 1'b1;
      r_show_prev <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      // Follows the state by one cycle so the game FSM sees a clean reset.
      r_fsm_rst   <= (r_state == S_IDLE) || (r_state == S_ARM) || (r_state == S_DONE);
      r_show_prev <= iShowTimerErrorDisplay;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_show_rise   = iShowTimerErrorDisplay & ~r_show_prev;
    w_count_inc   = r_trial_count + 5'd1;
    w_clear_stats = 1'b0;
    w_capture     = 1'b0;
    w_record      = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          w_state_next  = S_ARM;
          w_clear_stats = 1'b1;
        end
      end
      S_ARM: w_state_next = S_RUN;
      S_RUN: begin
        if (w_show_rise) begin
          w_state_next = S_RECORD;
          w_capture    = 1'b1;
        end
      end
      S_RECORD: begin
        w_record     = 1'b1;
        w_state_next = (w_count_inc == TRIALS) ? S_DONE : S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (!iShowTimerErrorDisplay) begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Trial capture and statistics
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cap_time <= '0;
      r_cap_err  <= '0;
    end else if (w_capture) begin
      r_cap_time <= r_timer;
      r_cap_err  <= iButtonError;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || w_clear_stats) begin
      r_trial_count <= '0;
      r_best        <= '1;
      r_total       <= '0;
      r_wrong       <= '0;
      r_timeout     <= '0;
    end else if (w_record) begin
      r_trial_count <= w_count_inc;
      unique case (r_cap_err)
        2'b00: begin
          r_total <= r_total + {4'b0000, r_cap_time};
          if (r_cap_time < r_best) begin
            r_best <= r_cap_time;
          end
        end
        2'b01:   r_wrong   <= r_wrong + 5'd1;
        2'b10:   r_timeout <= r_timeout + 5'd1;
        default: ;
      endcase
    end
  end

  assign oFsmRst          = r_fsm_rst;
  assign oTimer16         = r_timer;
  assign oButtonRequested = r_button;
  assign oTrialCount      = r_trial_count;
  assign oBestTime        = r_best;
  assign oTotalTime       = r_total;
  assign oWrongCount      = r_wrong;
  assign oTimeoutCount    = r_timeout;
  assign oSessionDone     = (r_state == S_DONE);
  assign oBusy            = (r_state == S_ARM) || (r_state == S_RUN) ||
                            (r_state == S_RECORD) || (r_state == S_WAIT_RELEASE);

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Bench for reaction_session_ctrl: two instances (8 and 2 trials per session)
// share one stimulus stream and are checked every cycle against a behavioural
// model, plus literal expectations at the key points of each scenario.
module tb_reaction_session_ctrl;

  logic       clk = 1'b0;
  logic       iRst = 1'b1;
  logic       iStart = 1'b0;
  logic       iResetTimer = 1'b0;
  logic       iNewButtonReq = 1'b0;
  logic       iShow = 1'b0;
  logic [1:0] iErr = 2'b00;

  logic        o0_frst, o1_frst, o0_done, o1_done, o0_busy, o1_busy;
  logic [15:0] o0_tmr, o1_tmr, o0_best, o1_best;
  logic [2:0]  o0_btn, o1_btn;
  logic [4:0]  o0_cnt, o1_cnt, o0_wr, o1_wr, o0_to, o1_to;
  logic [19:0] o0_tot, o1_tot;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reaction_session_ctrl #(.CLK_FREQ_HZ(4000), .NUM_TRIALS(8), .LFSR_SEED(8'hA5)) u_dut0 (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iResetTimer(iResetTimer),
    .iNewButtonReq(iNewButtonReq), .iShowTimerErrorDisplay(iShow), .iButtonError(iErr),
    .oFsmRst(o0_frst), .oTimer16(o0_tmr), .oButtonRequested(o0_btn), .oTrialCount(o0_cnt),
    .oBestTime(o0_best), .oTotalTime(o0_tot), .oWrongCount(o0_wr), .oTimeoutCount(o0_to),
    .oSessionDone(o0_done), .oBusy(o0_busy));

  reaction_session_ctrl #(.CLK_FREQ_HZ(4000), .NUM_TRIALS(2), .LFSR_SEED(8'hA5)) u_dut1 (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iResetTimer(iResetTimer),
    .iNewButtonReq(iNewButtonReq), .iShowTimerErrorDisplay(iShow), .iButtonError(iErr),
    .oFsmRst(o1_frst), .oTimer16(o1_tmr), .oButtonRequested(o1_btn), .oTrialCount(o1_cnt),
    .oBestTime(o1_best), .oTotalTime(o1_tot), .oWrongCount(o1_wr), .oTimeoutCount(o1_to),
    .oSessionDone(o1_done), .oBusy(o1_busy));

  task automatic check(input string nm, input int k, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %0h, expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_REC = 3, P_WAIT = 4, P_DONE = 5;
  int          m_nt [2] = '{8, 2};
  longint      m_cyc;               // cycles since last timer clear
  logic [7:0]  m_lfsr;
  logic [2:0]  m_btn;
  bit          m_prev;
  int          m_phase [2];
  bit          m_frst [2];
  int          m_n [2];             // recorded trials
  logic [15:0] m_t [2][16];         // recorded times
  logic [1:0]  m_e [2][16];         // recorded error codes
  logic [15:0] m_cap_t [2];
  logic [1:0]  m_cap_e [2];

  function automatic logic [15:0] timer_now();
    longint q = m_cyc / 4;
    return (q > 65535) ? 16'hFFFF : 16'(q);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] taps = 8'hB8;       // bit positions 8,6,5,4 of the polynomial
    return {s[6:0], ^(s & taps)};
  endfunction

  function automatic logic [15:0] exp_best(input int k);
    logic [15:0] b = 16'hFFFF;
    for (int i = 0; i < m_n[k]; i++)
      if (m_e[k][i] == 2'b00 && m_t[k][i] < b) b = m_t[k][i];
    return b;
  endfunction

  function automatic logic [19:0] exp_total(input int k);
    int s = 0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_e[k][i] == 2'b00) s += int'(m_t[k][i]);
    return 20'(s);
  endfunction

  function automatic logic [4:0] exp_count(input int k, input logic [1:0] code);
    int c = 0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_e[k][i] == code) c++;
    return 5'(c);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_lfsr = 8'hA5; m_btn = 3'b001; m_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE; m_frst[k] = 1'b1; m_n[k] = 0;
      m_cap_t[k] = '0; m_cap_e[k] = '0;
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    int old;
    if (iRst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      old = m_phase[k];
      m_frst[k] = (old == P_IDLE) || (old == P_ARM) || (old == P_DONE);
      case (old)
        P_IDLE, P_DONE: if (iStart) begin m_phase[k] = P_ARM; m_n[k] = 0; end
        P_ARM: m_phase[k] = P_RUN;
        P_RUN: if (iShow && !m_prev) begin
          m_cap_t[k] = timer_now(); m_cap_e[k] = iErr; m_phase[k] = P_REC;
        end
        P_REC: begin
          m_t[k][m_n[k]] = m_cap_t[k]; m_e[k][m_n[k]] = m_cap_e[k];
          m_n[k]++;
          m_phase[k] = (m_n[k] == m_nt[k]) ? P_DONE : P_WAIT;
        end
        P_WAIT: if (!iShow) m_phase[k] = P_RUN;
        default: m_phase[k] = P_IDLE;
      endcase
    end
    m_prev = iShow;
    if (iNewButtonReq)
      case (m_lfsr[1:0])
        2'b01: m_btn = 3'b010;
        2'b10: m_btn = 3'b100;
        default: m_btn = 3'b001;
      endcase
    m_lfsr = lfsr_next(m_lfsr);
    if (iResetTimer) m_cyc = 0; else m_cyc++;
  endtask

  task automatic cmp_inst(input int k, input logic frst, input logic [15:0] tmr, input logic [2:0] btn,
                          input logic [4:0] cnt, input logic [15:0] best, input logic [19:0] tot,
                          input logic [4:0] wr, input logic [4:0] to, input logic done, input logic busy);
    check("fsmrst", k, 20'(frst), 20'(m_frst[k]));
    check("timer", k, 20'(tmr), 20'(timer_now()));
    check("button", k, 20'(btn), 20'(m_btn));
    check("trials", k, 20'(cnt), 20'(m_n[k]));
    check("best", k, 20'(best), 20'(exp_best(k)));
    check("total", k, tot, exp_total(k));
    check("wrong", k, 20'(wr), 20'(exp_count(k, 2'b01)));
    check("timeouts", k, 20'(to), 20'(exp_count(k, 2'b10)));
    check("done", k, 20'(done), 20'(m_phase[k] == P_DONE));
    check("busy", k, 20'(busy), 20'(m_phase[k] >= P_ARM && m_phase[k] <= P_WAIT));
  endtask

  // Compare on every falling edge, then advance the model to the next edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cmp_inst(0, o0_frst, o0_tmr, o0_btn, o0_cnt, o0_best, o0_tot, o0_wr, o0_to, o0_done, o0_busy);
      cmp_inst(1, o1_frst, o1_tmr, o1_btn, o1_cnt, o1_best, o1_tot, o1_wr, o1_to, o1_done, o1_busy);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Show rises while the timer reads exactly t ms after a fresh clear.
  task automatic run_trial(input int t, input logic [1:0] e);
    iErr = e;
    iResetTimer = 1'b1; tick(); iResetTimer = 1'b0;
    iNewButtonReq = 1'b1; tick(); iNewButtonReq = 1'b0;
    repeat (4 * t - 1) tick();
    iShow = 1'b1; tick();
    repeat (3) tick();
    iShow = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_fsmrst", 0, 20'(o0_frst), 20'd1);
    check("rst_best", 0, 20'(o0_best), 20'hFFFF);
    check("rst_button", 0, 20'(o0_btn), 20'd1);
    iRst = 1'b0;
    repeat (40) tick();
    check("idle_timer10", 0, 20'(o0_tmr), 20'd10);
    check("idle_fsmrst", 0, 20'(o0_frst), 20'd1);
    check("idle_trials", 0, 20'(o0_cnt), 20'd0);
    iResetTimer = 1'b1; tick(); iResetTimer = 1'b0;
    check("timer_clear", 0, 20'(o0_tmr), 20'd0);

    iStart = 1'b1; tick(); iStart = 1'b0;
    run_trial(250, 2'b00);
    run_trial(180, 2'b00);
    run_trial(300, 2'b00);
    check("A_trials", 0, 20'(o0_cnt), 20'd3);
    check("A_best", 0, 20'(o0_best), 20'd180);
    check("A_total", 0, o0_tot, 20'd730);
    check("A_wrong", 0, 20'(o0_wr), 20'd0);
    check("A2_trials", 1, 20'(o1_cnt), 20'd2);
    check("A2_total", 1, o1_tot, 20'd430);
    check("A2_done", 1, 20'(o1_done), 20'd1);

    // inst 0 is in RUN and must ignore this; inst 1 restarts from DONE.
    iStart = 1'b1; tick(); iStart = 1'b0; tick();
    check("start_in_run", 0, 20'(o0_cnt), 20'd3);
    check("restart_clear", 1, 20'(o1_cnt), 20'd0);
    check("restart_best", 1, 20'(o1_best), 20'hFFFF);
    run_trial(50, 2'b01);
    run_trial(70, 2'b10);
    check("B_wrong", 1, 20'(o1_wr), 20'd1);
    check("B_timeouts", 1, 20'(o1_to), 20'd1);
    check("B_best", 1, 20'(o1_best), 20'hFFFF);
    check("B_done", 1, 20'(o1_done), 20'd1);
    check("B_fsmrst", 1, 20'(o1_frst), 20'd1);
    check("B_trials0", 0, 20'(o0_cnt), 20'd5);
    run_trial(180, 2'b00);
    check("tie_best", 0, 20'(o0_best), 20'd180);
    check("tie_total", 0, o0_tot, 20'd910);

    repeat (262200) tick();
    check("saturate", 0, 20'(o0_tmr), 20'hFFFF);
    repeat (8) tick();
    check("saturate_hold", 0, 20'(o0_tmr), 20'hFFFF);

    for (int i = 0; i < 20; i++) begin
      iNewButtonReq = 1'b1; tick(); iNewButtonReq = 1'b0;
      check("onehot", 0, 20'($onehot(o0_btn)), 20'd1);
      repeat (i % 3) tick();
    end

    // Reset while inst 0 waits for the display to drop.
    iShow = 1'b1; repeat (3) tick();
    check("pre_rst_trials", 0, 20'(o0_cnt), 20'd7);
    iRst = 1'b1; tick(); iRst = 1'b0; iShow = 1'b0;
    check("mid_rst_trials", 0, 20'(o0_cnt), 20'd0);
    check("mid_rst_busy", 0, 20'(o0_busy), 20'd0);
    check("mid_rst_total", 0, o0_tot, 20'd0);
    check("mid_rst_fsmrst", 0, 20'(o0_frst), 20'd1);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
